// File: rtl/addn_pkg.sv
// Shared constants, stage-count helper and per-stage control record for the
// sliced pipelined adder.
package addn_pkg;

   localparam int SLICE_W = 4;

   function automatic int calc_stages(input int width);
      return width / SLICE_W;
   endfunction

   // Control state carried by every pipeline stage.
   typedef struct packed {
      logic vld;
      logic cout;
   } stg_ctl_t;

endpackage

// File: rtl/add_slice4.sv
// Combinational 4-bit ripple slice; c3 is the carry into the slice's top bit
// so the last stage can form the signed-overflow flag.
module add_slice4
   import addn_pkg::*;
(
   input  logic [SLICE_W-1:0] a,
   input  logic [SLICE_W-1:0] b,
   input  logic               cin,
   output logic [SLICE_W-1:0] s,
   output logic               cout,
   output logic               c3
);

   logic [SLICE_W:0] c;

   always_comb begin
      s    = '0;
      c    = '0;
      c[0] = cin;
      for (int i = 0; i < SLICE_W; i++) begin
         s[i]   = a[i] ^ b[i] ^ c[i];
         c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
      end
   end

   assign cout = c[SLICE_W];
   assign c3   = c[SLICE_W-1];

endmodule

// File: rtl/addn_pipe.sv
// Pipelined WIDTH-bit add/sub: one 4-bit slice per stage, carry registered
// between stages, single global enable for valid/ready backpressure.
module addn_pipe
   import addn_pkg::*;
#(
   parameter  int WIDTH  = 16,
   localparam int STAGES = calc_stages(WIDTH)
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   input  logic             in_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_ovf
);

   if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W) begin : g_bad_width
      $error("addn_pipe: WIDTH must be a positive multiple of 4");
   end

   logic              en;
   logic [STAGES-1:0] vld_pipe;

   assign en        = !out_valid | out_ready;
   assign in_ready  = en;
   assign out_valid = vld_pipe[STAGES-1];

   for (genvar k = 0; k < STAGES; k++) begin : g_stg
      localparam int OPW = WIDTH - SLICE_W*k;   // operand bits still to be summed
      localparam int SW  = SLICE_W*(k+1);       // result bits complete after this stage

      logic [OPW-1:0]     a_i, b_i;
      logic [SW-1:0]      sacc;
      logic [SLICE_W-1:0] s;
      logic               cin_i, vld_i, co, c3;
      logic [SW-1:0]      s_q;
      stg_ctl_t           ctl_q;

      if (k == 0) begin : g_src
         // Subtract is A + ~B + 1; inversion happens before any register.
         assign a_i   = in_a;
         assign b_i   = in_sub ? ~in_b : in_b;
         assign cin_i = in_sub | in_cin;
         assign vld_i = in_valid;
         assign sacc  = s;
      end else begin : g_src
         assign a_i   = g_stg[k-1].g_hi.a_q;
         assign b_i   = g_stg[k-1].g_hi.b_q;
         assign cin_i = g_stg[k-1].ctl_q.cout;
         assign vld_i = vld_pipe[k-1];
         assign sacc  = {s, g_stg[k-1].s_q};
      end

      add_slice4 u_slice (
         .a    (a_i[SLICE_W-1:0]),
         .b    (b_i[SLICE_W-1:0]),
         .cin  (cin_i),
         .s    (s),
         .cout (co),
         .c3   (c3)
      );

      // Data only moves with a valid beat so the out registers stay 0
      // after reset until real data arrives.
      always_ff @(posedge clk) begin
         if (rst) begin
            ctl_q <= '0;
            s_q   <= '0;
         end else if (en) begin
            ctl_q.vld <= vld_i;
            if (vld_i) begin
               ctl_q.cout <= co;
               s_q        <= sacc;
            end
         end
      end

      assign vld_pipe[k] = ctl_q.vld;

      if (k == STAGES-1) begin : g_last
         logic c3_q;

         always_ff @(posedge clk) begin
            if (rst)              c3_q <= 1'b0;
            else if (en && vld_i) c3_q <= c3;
         end

         assign out_sum  = s_q;
         assign out_cout = ctl_q.cout;
         assign out_ovf  = c3_q ^ ctl_q.cout;
      end else begin : g_hi
         logic [OPW-SLICE_W-1:0] a_q, b_q;

         always_ff @(posedge clk) begin
            if (rst) begin
               a_q <= '0;
               b_q <= '0;
            end else if (en && vld_i) begin
               a_q <= a_i[OPW-1:SLICE_W];
               b_q <= b_i[OPW-1:SLICE_W];
            end
         end
      end
   end

endmodule

// File: tb/tb_addn_pipe.sv
// Scoreboard bench for addn_pipe (WIDTH=16): driver pushes expected results on
// accept, an independent monitor pops and compares on every output beat.
module tb_addn_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, in_cin, in_sub;
   logic [15:0] in_a, in_b;
   logic        out_valid, out_ready, out_cout, out_ovf;
   logic [15:0] out_sum;

   typedef struct {
      logic [15:0] sum;
      logic        cout;
      logic        ovf;
   } exp_t;

   exp_t scb[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   bit   rnd_done;

   addn_pipe #(.WIDTH(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_cin    (in_cin),
      .in_sub    (in_sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_cout  (out_cout),
      .out_ovf   (out_ovf)
   );

   always #5 clk = ~clk;

   // Reference: plain integer arithmetic on the operands.
   function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                  input logic cin, input logic sub);
      exp_t        e;
      logic [16:0] full;
      int          sa, sbv, r;
      sa  = $signed(a);
      sbv = $signed(b);
      if (sub) begin
         full = {1'b0, a} + ({1'b0, ~b} + 17'd1);
         r    = sa - sbv;
      end else begin
         full = {1'b0, a} + {1'b0, b} + {16'd0, cin};
         r    = sa + sbv + int'(cin);
      end
      e.sum  = full[15:0];
      e.cout = full[16];
      e.ovf  = (r > 32767) || (r < -32768);
      return e;
   endfunction

   // Called at posedge+#1; returns at posedge+#1 after the accepting edge.
   task automatic send(input logic [15:0] a, input logic [15:0] b,
                       input logic cin, input logic sub, input exp_t e);
      int waitc = 0;
      in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
      forever begin
         @(negedge clk);
         if (in_ready) begin
            scb.push_back(e);
            break;
         end
         waitc++;
         if (waitc > 200) begin
            n_cmp++; n_bad++;
            $display("FAIL accept_timeout a=%h b=%h never accepted", a, b);
            break;
         end
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic send_k(input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic sub,
                         input logic [15:0] es, input logic ec, input logic eo);
      exp_t e;
      e.sum = es; e.cout = ec; e.ovf = eo;
      send(a, b, cin, sub, e);
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 200; i++) begin
         @(posedge clk);
         if (scb.size() == 0) break;
      end
      #1;
      n_cmp++;
      if (scb.size() != 0) begin
         n_bad++;
         $display("FAIL %s_drain pending=%0d required=0", tag, scb.size());
      end
   endtask

   task automatic check_idle(input string tag);
      n_cmp++;
      if (out_valid !== 1'b0 || out_sum !== 16'h0 || out_cout !== 1'b0 || out_ovf !== 1'b0) begin
         n_bad++;
         $display("FAIL %s got vld=%b sum=%h cout=%b ovf=%b required all 0",
                  tag, out_valid, out_sum, out_cout, out_ovf);
      end
   endtask

   // Monitor: compare the head of the scoreboard whenever a result is presented.
   always @(negedge clk) begin
      if (!rst && out_valid) begin
         n_cmp++;
         if (scb.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_beat got sum=%h cout=%b ovf=%b", out_sum, out_cout, out_ovf);
         end else begin
            if (out_sum !== scb[0].sum || out_cout !== scb[0].cout || out_ovf !== scb[0].ovf) begin
               n_bad++;
               $display("FAIL result got sum=%h cout=%b ovf=%b required sum=%h cout=%b ovf=%b",
                        out_sum, out_cout, out_ovf, scb[0].sum, scb[0].cout, scb[0].ovf);
            end
            if (out_ready) void'(scb.pop_front());
         end
         if (!out_ready) begin
            n_cmp++;
            if (in_ready !== 1'b0) begin
               n_bad++;
               $display("FAIL stall_in_ready got %b required 0", in_ready);
            end
         end
      end
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0;
      out_ready = 1'b0; rnd_done = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_idle("reset_outputs");
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL reset_in_ready got %b required 1", in_ready);
      end
      @(posedge clk); #1;
      rst = 1'b0; out_ready = 1'b1;

      // 1: basic add with carry-in, latency and single-cycle valid pulse
      send_k(16'h1234, 16'h0FF0, 1'b1, 1'b0, 16'h2225, 1'b0, 1'b0);
      for (int j = 0; j < 5; j++) begin
         @(negedge clk);
         n_cmp++;
         if (out_valid !== (j == 3)) begin
            n_bad++;
            $display("FAIL latency_j%0d got out_valid=%b required %b", j, out_valid, (j == 3));
         end
      end
      @(posedge clk); #1;

      // 2 & 3: overflow / wrap / subtract boundaries
      send_k(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
      send_k(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      send_k(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      send_k(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
      drain("directed");

      // 4: back-to-back stream with a 4-cycle output stall
      fork
         begin
            for (int i = 0; i < 8; i++) begin
               logic [15:0] a, b;
               a = 16'(i);
               b = 16'(i * 16'h0101);
               send(a, b, 1'b0, 1'b0, model(a, b, 1'b0, 1'b0));
            end
         end
         begin
            repeat (6) begin @(posedge clk); #1; end
            out_ready = 1'b0;
            repeat (4) begin @(posedge clk); #1; end
            out_ready = 1'b1;
         end
      join
      drain("stream");

      // 5: reset with beats in flight discards them
      send_k(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0);
      send_k(16'h0101, 16'h0202, 1'b0, 1'b0, 16'h0303, 1'b0, 1'b0);
      send_k(16'h4000, 16'h4000, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
      rst = 1'b1;
      scb.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      for (int j = 0; j < 5; j++) begin
         @(negedge clk);
         check_idle("post_reset_idle");
      end
      @(posedge clk); #1;
      send_k(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);
      drain("post_reset");

      // 6: random operands, bubbles and backpressure
      fork
         begin
            while (!rnd_done) begin
               @(posedge clk); #1;
               out_ready = ($urandom_range(0, 3) != 0);
            end
         end
         begin
            for (int i = 0; i < 1000; i++) begin
               logic [15:0] a, b;
               logic        c, s;
               a = 16'($urandom);
               b = 16'($urandom);
               c = 1'($urandom);
               s = 1'($urandom);
               send(a, b, c, s, model(a, b, c, s));
               repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            end
            rnd_done = 1'b1;
         end
      join
      out_ready = 1'b1;
      drain("random");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
